// File: rtl/noc16_aes_host_if.sv
// Local stream (pt/ct) and NOC16 link signals of the AES host initiator.
// slave is the initiator's view; master is the environment/peripheral view.
interface noc16_aes_host_if;
  logic         pt_valid;
  logic [127:0] pt_data;
  logic         pt_rdy;
  logic         ct_valid;
  logic [127:0] ct_data;
  logic         ct_rdy;
  logic [63:0]  Noc16_TxData_lo;
  logic [7:0]   Noc16_TxData_cmd;
  logic         Noc16_TxData_valid;
  logic         Noc16_TxData_rdy;
  logic [63:0]  Noc16_RxData_lo;
  logic [7:0]   Noc16_RxData_cmd;
  logic         Noc16_RxData_valid;
  logic         Noc16_RxData_rdy;

  modport slave (
    input  pt_valid, pt_data, ct_rdy, Noc16_TxData_rdy,
           Noc16_RxData_lo, Noc16_RxData_cmd, Noc16_RxData_valid,
    output pt_rdy, ct_valid, ct_data, Noc16_TxData_lo, Noc16_TxData_cmd,
           Noc16_TxData_valid, Noc16_RxData_rdy
  );

  modport master (
    output pt_valid, pt_data, ct_rdy, Noc16_TxData_rdy,
           Noc16_RxData_lo, Noc16_RxData_cmd, Noc16_RxData_valid,
    input  pt_rdy, ct_valid, ct_data, Noc16_TxData_lo, Noc16_TxData_cmd,
           Noc16_TxData_valid, Noc16_RxData_rdy
  );
endinterface

// File: rtl/noc16_aes_host.sv
// NOC16 initiator for the AES-128 CBC peripheral: streams round keys and IV,
// splits plaintext into two cmd-2 words and rebuilds ciphertext from two 0xFF beats.
module noc16_aes_host #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_key_we,
  input  logic [4:0]   i_key_addr,
  input  logic [63:0]  i_key_wdata,
  input  logic         i_iv_we,
  input  logic [127:0] i_iv_wdata,
  input  logic         i_load_go,
  output logic         o_busy,
  output logic [15:0]  o_blocks_done,
  output logic         o_err_unexpected,
  output logic         o_err_timeout,
  noc16_aes_host_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SEND_KEY, SEND_IV, SEND_PT_LO, SEND_PT_HI, WAIT_LO, WAIT_HI
  } state_t;

  state_t        r_state;
  logic [63:0]   r_key [0:21];
  logic [127:0]  r_iv;
  logic [63:0]   r_pt_hi;
  logic [63:0]   r_ct_lo;
  logic [127:0]  r_ct;
  logic          r_ct_valid;
  logic [4:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic [63:0]   r_tx_lo;
  logic [7:0]    r_tx_cmd;
  logic          r_tx_valid;
  logic          r_rx_rdy;
  logic [15:0]   r_blocks;
  logic          r_err_unexp;
  logic          r_err_tmo;

  logic       w_fire;
  logic       w_rx_ff;
  logic       w_waiting;
  logic       w_pt_rdy;
  logic       w_tmo_hit;
  logic [4:0] w_kidx;

  assign w_fire    = r_tx_valid && bus.Noc16_TxData_rdy;
  assign w_rx_ff   = bus.Noc16_RxData_valid && (bus.Noc16_RxData_cmd == 8'hFF);
  assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);
  // r_rx_rdy doubles as "out of reset" so pt_rdy reads 0 while reset is held
  assign w_pt_rdy  = r_rx_rdy && (r_state == IDLE) && !r_ct_valid && !i_load_go;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
  assign w_kidx    = r_idx + 5'd1;

  assign bus.pt_rdy             = w_pt_rdy;
  assign bus.ct_valid           = r_ct_valid;
  assign bus.ct_data            = r_ct;
  assign bus.Noc16_TxData_lo    = r_tx_lo;
  assign bus.Noc16_TxData_cmd   = r_tx_cmd;
  assign bus.Noc16_TxData_valid = r_tx_valid;
  assign bus.Noc16_RxData_rdy   = r_rx_rdy;
  assign o_busy                 = (r_state != IDLE);
  assign o_blocks_done          = r_blocks;
  assign o_err_unexpected       = r_err_unexp;
  assign o_err_timeout          = r_err_tmo;

  // Key/IV storage is intentionally unreset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && i_key_we && i_key_addr < 5'd22) r_key[i_key_addr] <= i_key_wdata;
    if (r_state == IDLE && i_iv_we) r_iv <= i_iv_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pt_hi     <= '0;
      r_ct_lo     <= '0;
      r_ct        <= '0;
      r_ct_valid  <= 1'b0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_tx_lo     <= '0;
      r_tx_cmd    <= '0;
      r_tx_valid  <= 1'b0;
      r_rx_rdy    <= 1'b0;
      r_blocks    <= '0;
      r_err_unexp <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_rx_rdy <= 1'b1;
      if (r_ct_valid && bus.ct_rdy) r_ct_valid <= 1'b0;
      if (w_rx_ff && !w_waiting) r_err_unexp <= 1'b1;
      // Valid is only (re)raised when rdy was seen high; a stall drops it
      // and the same word is re-presented once rdy returns.
      case (r_state)
        IDLE: begin
          if (i_load_go) begin
            r_state    <= SEND_KEY;
            r_idx      <= '0;
            r_tx_lo    <= r_key[0];
            r_tx_cmd   <= 8'h00;
            r_tx_valid <= bus.Noc16_TxData_rdy;
          end else if (bus.pt_valid && w_pt_rdy) begin
            r_pt_hi    <= bus.pt_data[127:64];
            r_state    <= SEND_PT_LO;
            r_tx_lo    <= bus.pt_data[63:0];
            r_tx_cmd   <= 8'h02;
            r_tx_valid <= bus.Noc16_TxData_rdy;
          end
        end
        SEND_KEY: begin
          if (w_fire) begin
            if (r_idx == 5'd21) begin
              r_state  <= SEND_IV;
              r_idx    <= '0;
              r_tx_lo  <= r_iv[63:0];
              r_tx_cmd <= 8'h01;
            end else begin
              r_idx   <= w_kidx;
              r_tx_lo <= r_key[w_kidx];
            end
          end else r_tx_valid <= bus.Noc16_TxData_rdy;
        end
        SEND_IV: begin
          if (w_fire) begin
            if (r_idx == 5'd0) begin
              r_idx   <= 5'd1;
              r_tx_lo <= r_iv[127:64];
            end else begin
              r_state    <= IDLE;
              r_tx_valid <= 1'b0;
            end
          end else r_tx_valid <= bus.Noc16_TxData_rdy;
        end
        SEND_PT_LO: begin
          if (w_fire) begin
            r_state <= SEND_PT_HI;
            r_tx_lo <= r_pt_hi;
          end else r_tx_valid <= bus.Noc16_TxData_rdy;
        end
        SEND_PT_HI: begin
          if (w_fire) begin
            r_state    <= WAIT_LO;
            r_tx_valid <= 1'b0;
            r_tmo      <= '0;
          end else r_tx_valid <= bus.Noc16_TxData_rdy;
        end
        WAIT_LO, WAIT_HI: begin
          if (w_rx_ff && r_state == WAIT_LO) begin
            r_ct_lo <= bus.Noc16_RxData_lo;
            r_state <= WAIT_HI;
            r_tmo   <= r_tmo + TW'(1);
          end else if (w_rx_ff) begin
            r_ct       <= {bus.Noc16_RxData_lo, r_ct_lo};
            r_ct_valid <= 1'b1;
            r_blocks   <= r_blocks + 16'd1;
            r_state    <= IDLE;
          end else if (w_tmo_hit) begin
            r_err_tmo <= 1'b1;
            r_state   <= IDLE;
          end else r_tmo <= r_tmo + TW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/noc16_aes_host.md
# noc16_aes_host

Host-side NOC16 initiator for the AES-128 CBC encryption peripheral. It holds the 22 round-key words and the IV, and streams them to the peripheral on request (cmd 0 / cmd 1). It serializes 128-bit plaintext blocks into two cmd-2 words and reassembles the two cmd-0xFF result beats into 128-bit ciphertext. It sits between a local register/stream master and the peripheral's NOC16 ports, with one block outstanding at a time.

## Interface
- TIMEOUT, 64: cycles allowed in WAIT_LO/WAIT_HI before abort.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- key_we / key_addr / key_wdata  in  1/5/64  write round-key word key_addr (0..21); addr ≥22 ignored.
- iv_we / iv_wdata  in  1/128  write IV.
- load_go  in  1  pulse: send key then IV to peripheral.
- pt_valid / pt_data  in  1/128  plaintext block; pt_rdy  out  1.
- ct_valid / ct_data  out  1/128  ciphertext block; ct_rdy  in  1.
- Noc16_TxData_lo / _cmd / _valid  out  64/8/1  to peripheral RxData; Noc16_TxData_rdy  in  1  from peripheral.
- Noc16_RxData_lo / _cmd / _valid  in  64/8/1  from peripheral TxData; Noc16_RxData_rdy  out  1.
- busy  out  1  state ≠ IDLE.
- blocks_done  out  16  completed-block counter, wraps 0xFFFF→0.
- err_unexpected / err_timeout  out  1  sticky error flags; cleared only by reset.

## Operation
- States: IDLE, SEND_KEY, SEND_IV, SEND_PT_LO, SEND_PT_HI, WAIT_LO, WAIT_HI.
- IDLE:
  - load_go → SEND_KEY with word index 0.
  - Else pt_valid && pt_rdy → latch pt_data → SEND_PT_LO.
  - load_go has priority; pt is not accepted that cycle.
- pt_rdy = (state==IDLE) && !ct_valid && !load_go.
- SEND_KEY: present key[i] with cmd 0x00, i = 0..21 in order. After word 21 is accepted → SEND_IV.
- SEND_IV: present iv[63:0], then iv[127:64], both with cmd 0x01 → IDLE.
- SEND_PT_LO/HI: present pt[63:0], then pt[127:64], both with cmd 0x02 → WAIT_LO. Clear the timeout counter.
- WAIT_LO: Noc16_RxData_valid && cmd==0xFF → capture ct[63:0] → WAIT_HI.
- WAIT_HI: the same condition → capture ct[127:64]; set ct_valid; blocks_done+1 → IDLE.
- Rx beats with cmd ≠ 0xFF are ignored without error.
- A 0xFF beat received in any state other than WAIT_LO/WAIT_HI is dropped and sets err_unexpected.
- Timeout counter counts cycles in WAIT_LO/WAIT_HI. On reaching TIMEOUT: set err_timeout; discard the partial result; go to IDLE; blocks_done unchanged.
- key_we and iv_we are honoured only in IDLE and ignored otherwise, so arrays never change mid-transmission.
- Noc16_TxData_lo/_cmd hold their last value while valid is 0.
- CBC chaining is owned by the peripheral. This block never modifies the IV after loading.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Key array and IV are not reset and are undefined until written.
- Noc16_RxData_rdy is 0 in reset and 1 from the first edge after reset releases. The peripheral ignores this signal, so the block must capture every beat as it arrives.
- Tx handshake:
  - A word transfers on an edge with Noc16_TxData_valid && Noc16_TxData_rdy.
  - valid is registered and stays high with a stable word until transfer.
  - The next word is presented on the following cycle, so the link carries one word per cycle while rdy stays high.
  - Because the peripheral samples on valid alone, valid must be raised only in a cycle where Noc16_TxData_rdy is 1. If rdy is 0, valid is held low rather than pending.
- Minimum cycle counts:
  - load_go to return to IDLE: 24 transfer cycles + 1.
  - pt accept to first Tx word: 1 cycle.
  - Last Tx word to WAIT_LO: next edge.
- Result beats are consecutive-cycle lo then hi. ct_valid rises on the edge that captures the hi beat, with zero added gap.
- ct_valid holds with stable ct_data until ct_valid && ct_rdy; it clears on that edge. pt_rdy may rise the next cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values; the partial transfer is abandoned.

## Test plan
- Key/IV load: write key[i]=0x1111_0000_0000_0000+i and iv=0x0F0E…00, pulse load_go, rdy held 1 → 22 cmd-0 words in index order, then 2 cmd-1 words (lo, hi); busy high exactly 24 cycles.
- Backpressure: drop Noc16_TxData_rdy for 5 cycles at key word 7 → valid low during the stall, no word skipped or duplicated, word 7 resent after the stall.
- Encrypt round trip against a behavioural peripheral loaded with the FIPS-197 key: pt=0x00112233445566778899aabbccddeeff, iv=0 → cmd-2 words 0x8899aabbccddeeff then 0x0011223344556677; ct=0x69c4e0d86a7b0430d8cdb78070b4c55a; blocks_done=1.
- ct backpressure: hold ct_rdy=0 for 10 cycles with pt_valid=1 → pt_rdy stays 0 and ct_data stays stable; the second block is accepted the cycle after ct_rdy rises.
- Timeout/unexpected: TIMEOUT=64, no response → err_timeout at cycle 64, then IDLE. Inject a 0xFF beat in IDLE → err_unexpected=1 and blocks_done unchanged.
- Async reset mid-SEND_KEY at word 10 → outputs 0 immediately; after release, load_go restarts from word 0.
